// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types for the instruction fetch bridge.
// FSM encoding and the saturating miss-count helper.
package inst_fetch_bridge_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_ERR  = 2'b10
    } fetch_state_e;

    localparam logic [15:0] MISS_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(
        input logic [15:0] v
    );
        return (v == MISS_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/inst_fetch_bridge_sat_counter.sv
// 16-bit saturating event counter.
// Sticks at all-ones instead of wrapping.
module inst_fetch_bridge_sat_counter
    import inst_fetch_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // next count: bump on event, hold at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = sat_inc16(cnt_q);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/inst_fetch_bridge.sv
// CPU instruction port to req/ack memory bridge.
// One-line fetch buffer, miss stall, sticky timeout trap.
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [DATA_W-1:0] cpu_inst_o,
    output logic              cpu_stall_o,
    input  logic              inv_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic [15:0]       miss_cnt_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    fetch_state_e      state_q;
    logic              buf_valid_q;
    logic [ADDR_W-3:0] buf_tag_q;
    logic [DATA_W-1:0] buf_data_q;
    logic [ADDR_W-3:0] req_tag_q;
    logic [TW-1:0]     tmo_q;
    logic              err_q;
    logic              mem_req_q;

    logic hit;
    logic miss_issue;
    logic unused_addr_bits;

    // fetches are word aligned; byte offset carries no information
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit = cpu_ce_i && buf_valid_q
              && (buf_tag_q == cpu_addr_i[ADDR_W-1:2]);

    assign miss_issue = (state_q == FETCH_IDLE) && cpu_ce_i && !hit;

    // cpu-side mux: NOP in the trap, buffer on hit, stall on miss
    always_comb begin
        cpu_inst_o  = '0;
        cpu_stall_o = 1'b0;
        if (state_q == FETCH_ERR) begin
            if (cpu_ce_i) begin
                cpu_inst_o = NOP_INST;
            end
        end else if (hit) begin
            cpu_inst_o = buf_data_q;
        end else if (cpu_ce_i) begin
            cpu_stall_o = 1'b1;
        end
    end

    // fetch FSM with buffer, request and error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH_IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            req_tag_q   <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            // a same-cycle fill below overrides this clear
            if (inv_i) begin
                buf_valid_q <= 1'b0;
            end
            unique case (state_q)
                FETCH_IDLE: begin
                    if (miss_issue) begin
                        req_tag_q <= cpu_addr_i[ADDR_W-1:2];
                        tmo_q     <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (mem_ack_i) begin
                        buf_tag_q   <= req_tag_q;
                        buf_data_q  <= mem_rdata_i;
                        buf_valid_q <= 1'b1;
                        tmo_q       <= '0;
                        mem_req_q   <= 1'b0;
                        state_q     <= FETCH_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_q     <= tmo_q + TW'(1);
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= FETCH_ERR;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                FETCH_ERR: begin
                    state_q <= FETCH_ERR;
                end
                default: begin
                    state_q <= FETCH_IDLE;
                end
            endcase
        end
    end

    inst_fetch_bridge_sat_counter u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (miss_issue),
        .cnt_o (miss_cnt_o)
    );

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = {req_tag_q, 2'b00};
    assign err_o      = err_q;

endmodule
